// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and sizing helpers for the round-robin hold arbiter
//   Contents: arb_state_t (IDLE/GRANT), idx_width(), HOLD_W
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Hold counter width, sized for the largest MAX_HOLD (255).
    localparam int HOLD_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
//   Ports: i_req   [N]  request vector
//          i_ptr   [IW] highest-priority index
//          o_onehot[N]  one-hot winner (zero when none)
//          o_idx   [IW] winner index (zero when none)
//          o_found      any request present
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    logic [IW:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!o_found && i_req[w_cand[IW-1:0]]) begin
                o_found                     = 1'b1;
                o_onehot[w_cand[IW-1:0]]    = 1'b1;
                o_idx                       = w_cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// rtl/rr_hold_arbiter.sv - round-robin arbiter with bounded grant hold
//   Ports: clk, rst_b (async, active-low)
//          en        arbitration enable (blocks new grants only)
//          req  [N]  level requests
//          gnt  [N]  registered one-hot grant
//          gnt_valid registered, high when gnt != 0
//          gnt_idx   registered owner index, 0 when idle
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      en,
    input  logic [N-1:0]              req,
    output logic [N-1:0]              gnt,
    output logic                      gnt_valid,
    output logic [idx_width(N)-1:0]   gnt_idx
);

    localparam int IW = idx_width(N);

    arb_state_t        r_state;
    logic [IW-1:0]     r_ptr;
    logic [HOLD_W-1:0] r_hold;
    logic [N-1:0]      r_gnt;
    logic              r_valid;
    logic [IW-1:0]     r_idx;

    logic [IW-1:0]     w_next_ptr;
    logic [IW-1:0]     w_pick_ptr;
    logic              w_release;
    logic [N-1:0]      w_onehot;
    logic [IW-1:0]     w_idx;
    logic              w_found;

    // Pointer just past the current owner, folded at N-1.
    assign w_next_ptr = (r_idx == IW'(N-1)) ? '0 : r_idx + 1'b1;

    assign w_release  = !req[r_idx] || (r_hold == HOLD_W'(MAX_HOLD));

    // While granting, pick in the post-release order so a release can hand
    // over on the same edge. That order places the current owner last, which
    // lets a sole requester at MAX_HOLD win again.
    assign w_pick_ptr = (r_state == GRANT) ? w_next_ptr : r_ptr;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (w_pick_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_found  (w_found)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en && w_found) begin
                        r_state <= GRANT;
                        r_gnt   <= w_onehot;
                        r_idx   <= w_idx;
                        r_valid <= 1'b1;
                        r_hold  <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        if (en && w_found) begin
                            r_gnt   <= w_onehot;
                            r_idx   <= w_idx;
                            r_valid <= 1'b1;
                            r_hold  <= HOLD_W'(1);
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                            r_idx   <= '0;
                            r_valid <= 1'b0;
                            r_hold  <= '0;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_valid;
    assign gnt_idx   = r_idx;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb/tb_rr_hold_arbiter.sv - directed and random checks for rr_hold_arbiter
module tb_rr_hold_arbiter;

    logic       clk   = 1'b0;
    logic       rst_b = 1'b1;
    logic       en    = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_idx;

    int n_assert = 0;
    int n_fail   = 0;

    rr_hold_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        en    = 1'b0;
        rst_b = 1'b0;
        step();
        step();
        rst_b = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] ei);
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_vld"}, 32'(gnt_valid), 32'(eg != 4'b0000));
        chk({tag, "_idx"}, 32'(gnt_idx), 32'(ei));
    endtask

    logic [3:0] exp_g [10];
    logic [3:0] prev_req;
    logic       prev_en;
    int         wait_cnt [4];
    logic [1:0] e_idx;

    initial begin
        // Reset state
        #2 rst_b = 1'b0;
        #1;
        chk_out("rst", 4'b0000, 2'd0);
        chk("rst_ptr", 32'(dut.r_ptr), 32'd0);
        chk("rst_hold", 32'(dut.r_hold), 32'd0);
        step();
        rst_b = 1'b1;

        // Two requesters, MAX_HOLD rotation with no bubble
        req = 4'b1010;
        en  = 1'b1;
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                  4'b1000, 4'b1000, 4'b1000, 4'b1000,
                  4'b0010, 4'b0010};
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out($sformatf("alt%0d", i), exp_g[i], (exp_g[i] == 4'b1000) ? 2'd3 : 2'd1);
        end
        req = 4'b0000;
        step();
        chk_out("alt_drop", 4'b0000, 2'd0);

        // Sole requester regranted continuously
        do_reset();
        req = 4'b0001;
        en  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk_out($sformatf("solo%0d", i), 4'b0001, 2'd0);
            chk($sformatf("solo_hold%0d", i), 32'(dut.r_hold), 32'((i % 4) + 1));
            chk($sformatf("solo_ptr%0d", i), 32'(dut.r_ptr), (i >= 4) ? 32'd1 : 32'd0);
        end

        // Owner drops early, handover to 3 then wrap to 0
        do_reset();
        req = 4'b0100;
        en  = 1'b1;
        step();
        chk_out("drop_g2a", 4'b0100, 2'd2);
        req = 4'b1101;
        step();
        chk_out("drop_g2b", 4'b0100, 2'd2);
        req = 4'b1001;
        step();
        chk_out("drop_g3", 4'b1000, 2'd3);
        chk("drop_ptr3", 32'(dut.r_ptr), 32'd3);
        step(); step(); step();
        chk_out("drop_g3_held", 4'b1000, 2'd3);
        step();
        chk_out("drop_wrap", 4'b0001, 2'd0);
        chk("drop_ptr0", 32'(dut.r_ptr), 32'd0);

        // Enable gating and en falling mid-grant
        do_reset();
        req = 4'b1111;
        en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("en_off%0d", i), 4'b0000, 2'd0);
        end
        en = 1'b1;
        step();
        chk_out("en_on", 4'b0001, 2'd0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("en_hold%0d", i), 4'b0001, 2'd0);
        end
        step();
        chk_out("en_idle", 4'b0000, 2'd0);

        // Asynchronous reset mid-grant
        do_reset();
        req = 4'b0010;
        en  = 1'b1;
        step();
        req = 4'b0100;
        step();
        chk_out("ar_pre", 4'b0100, 2'd2);
        chk("ar_pre_ptr", 32'(dut.r_ptr), 32'd2);
        #2 rst_b = 1'b0;
        #1;
        chk_out("ar_mid", 4'b0000, 2'd0);
        chk("ar_mid_ptr", 32'(dut.r_ptr), 32'd0);
        step();
        rst_b = 1'b1;
        step();
        chk_out("ar_post", 4'b0100, 2'd2);
        chk("ar_post_ptr", 32'(dut.r_ptr), 32'd0);

        // Random traffic with invariant checks
        do_reset();
        req = 4'b0000;
        en  = 1'b1;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            req      = req ^ (4'($urandom) & 4'($urandom));
            en       = ($urandom_range(0, 15) != 0);
            prev_req = req;
            prev_en  = en;
            step();
            chk("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
            chk("rnd_valid", 32'(gnt_valid), 32'(gnt != 4'b0000));
            e_idx = 2'd0;
            for (int i = 0; i < 4; i++) if (gnt[i]) e_idx = 2'(i);
            chk("rnd_idx", 32'(gnt_idx), 32'(e_idx));
            chk("rnd_req_ok", 32'(gnt & ~prev_req), 32'd0);
            if (gnt_valid) begin
                chk("rnd_hold_le4", 32'(dut.r_hold >= 8'd1 && dut.r_hold <= 8'd4), 32'd1);
            end
            for (int i = 0; i < 4; i++) begin
                if (prev_req[i] && prev_en && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > 13) begin
                    chk($sformatf("rnd_starve%0d", i), 32'(wait_cnt[i]), 32'd13);
                    wait_cnt[i] = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_hold_arbiter.md
RR_HOLD_ARBITER -- requirements
Module: rr_hold_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters, legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive cycles one grant may be held, legal range 1..255.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst_b  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  1  arbitration enable; low blocks new grants only.
REQ-006 Port req  input  N  per-requester request, level-sensitive.
REQ-007 Port gnt  output  N  registered one-hot grant, all-zero when idle.
REQ-008 Port gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-009 Port gnt_idx  output  max(1,$clog2(N))  registered index of the granted requester; 0 when gnt_valid is low.

Function
REQ-010 The block SHALL keep a rotating pointer ptr (index width) naming the highest-priority requester; priority order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-011 The block SHALL implement the FSM states IDLE (no grant) and GRANT (owner holds gnt).
REQ-012 In IDLE with en=1 and req!=0, the next edge SHALL enter GRANT with owner = first set req bit in pointer order; grant latency is 1 cycle from req sampled.
REQ-013 In IDLE with en=0 or req=0, the FSM SHALL stay in IDLE and outputs SHALL stay zero.
REQ-014 In GRANT the block SHALL keep a hold counter, loaded to 1 on each new grant and incremented each cycle the grant is kept.
REQ-015 In GRANT, a release SHALL occur on an edge where req[owner]=0 or the hold counter equals MAX_HOLD.
REQ-016 Without release, gnt, gnt_idx and ptr SHALL stay unchanged regardless of other req bits or en.
REQ-017 On release, ptr SHALL become (owner+1) mod N; wrap from N-1 to 0.
REQ-018 On release with en=1 and any req bit set, the block SHALL grant the next owner on the same edge, chosen in the new pointer order, with no idle bubble.
- Req[owner] is included, at lowest priority, when the release is due to MAX_HOLD.
REQ-019 On release with en=0 or req=0, the FSM SHALL return to IDLE.
REQ-020 A sole requester reaching MAX_HOLD SHALL be regranted on the same edge with the counter reloaded to 1; gnt stays high continuously.
REQ-021 With MAX_HOLD=1, every grant SHALL last exactly one cycle, giving pure per-cycle round robin.
REQ-022 gnt SHALL never have more than one bit set and SHALL only assert a bit whose req was high at the granting edge.
REQ-023 en deasserting mid-grant SHALL NOT truncate the current grant.

Reset
REQ-024 Asserting rst_b low SHALL immediately set the FSM to IDLE, ptr=0, hold counter=0, gnt=0, gnt_valid=0 and gnt_idx=0, including mid-grant.
REQ-025 After rst_b deasserts, the first grant SHALL follow REQ-012 with ptr=0.

Structure
REQ-026 Shared package arb_pkg SHALL hold the FSM state enum (IDLE, GRANT) and a function or constant for the index width.
REQ-027 The combinational rotating-priority pick (req, ptr -> one-hot and index, found flag) SHALL be a sub-module rr_pick, instantiated once.
REQ-028 All outputs SHALL come directly from flops.

Verification (N=4, MAX_HOLD=4)
REQ-029 After reset, req=4'b1010 and en=1 held -> gnt=0010 from cycle 1 for 4 cycles, then 1000 for 4 cycles, then 0010; no zero cycle between grants.
REQ-030 req=4'b0001 held constantly -> gnt=0001 continuously; hold counter cycles 1,2,3,4,1; ptr toggles to 1 at each MAX_HOLD release.
REQ-031 Owner 2 drops req after 2 cycles while req[3] and req[0] are high -> next edge gnt=1000, ptr=3; after the next release gnt=0001 (wrap).
REQ-032 en=0 with req=4'b1111 from reset -> gnt stays 0; en rises -> gnt=0001 one cycle later; en falls mid-grant -> grant runs to MAX_HOLD, then IDLE.
REQ-033 rst_b asserted asynchronously mid-grant (gnt=0100) -> gnt=0, gnt_valid=0, gnt_idx=0 before the next edge; after release, req=4'b0100 -> gnt=0100 and ptr restarts from 0.
REQ-034 Random req/en for 10k cycles -> gnt one-hot or zero every cycle; gnt_valid equals |gnt; no grant exceeds 4 cycles; any requester held high is granted within 3*4+1 cycles.
